// File: rtl/video_frontend_ce_if.sv
// Raw core video into the front end and expanded, aligned video out to the mixer.
// The master modport is the core/mixer side; the slave modport is the front end.
interface video_frontend_ce_if;
  logic [2:0] r_i;
  logic [2:0] g_i;
  logic [2:0] b_i;
  logic       hs_i;
  logic       vs_i;
  logic       hblank_i;
  logic       vblank_i;

  logic       ce_pix_o;
  logic [7:0] r_o;
  logic [7:0] g_o;
  logic [7:0] b_o;
  logic       hs_o;
  logic       vs_o;
  logic       hblank_o;
  logic       vblank_o;
  logic       de_o;

  modport master (
    output r_i, g_i, b_i, hs_i, vs_i, hblank_i, vblank_i,
    input  ce_pix_o, r_o, g_o, b_o, hs_o, vs_o, hblank_o, vblank_o, de_o
  );

  modport slave (
    input  r_i, g_i, b_i, hs_i, vs_i, hblank_i, vblank_i,
    output ce_pix_o, r_o, g_o, b_o, hs_o, vs_o, hblank_o, vblank_o, de_o
  );
endinterface

// File: rtl/video_frontend_ce.sv
// ZX Next video front end: pixel enable from sampled clk7, 3:3:3 to 8:8:8 expansion,
// line/frame geometry measurement and clock-loss blanking. Optional: VIDEO_SCANLINE_DIM_EN.
module video_frontend_ce #(
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter int PAL_THRESHOLD    = 300,
  parameter int WDOG_CYCLES      = 16
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               clk7_i,
`ifdef VIDEO_SCANLINE_DIM_EN
  input  logic               scanline_en_i,
`endif
  video_frontend_ce_if.slave vid,
  output logic [9:0]         h_total_o,
  output logic [9:0]         v_total_o,
  output logic               pal_o,
  output logic               timing_valid_o,
  output logic               clk_lost_o
);

  localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
  localparam logic [9:0]      CNT_MAX = 10'h3FF;

  logic            s1_reg, s2_reg, s3_reg;
  logic            ce_int;
  logic            ce_pix_reg;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            lost_reg, lost_next;

  logic            hs_act, vs_act, blank_in;
  logic            hs_prev_reg, hs_prev_next;
  logic            vs_prev_reg, vs_prev_next;
  logic            line_start, frame_start;

  logic            hs_reg, hs_next;
  logic            vs_reg, vs_next;
  logic            hblank_reg, hblank_next;
  logic            vblank_reg, vblank_next;

  logic [9:0]      h_cnt_reg, h_cnt_next;
  logic [9:0]      v_cnt_reg, v_cnt_next;
  logic [9:0]      h_total_reg, h_total_next;
  logic [9:0]      v_total_reg, v_total_next;
  logic [9:0]      ref_h_reg, ref_h_next;
  logic [9:0]      ref_v_reg, ref_v_next;
  logic [9:0]      h_meas;
  logic            have_ref_reg, have_ref_next;
  logic            pal_reg, pal_next;
  logic            valid_reg, valid_next;

  logic [2:0][2:0] col_in;

  assign ce_int      = s2_reg & ~s3_reg;
  assign hs_act      = SYNC_ACTIVE_HIGH ? vid.hs_i : ~vid.hs_i;
  assign vs_act      = SYNC_ACTIVE_HIGH ? vid.vs_i : ~vid.vs_i;
  assign blank_in    = vid.hblank_i | vid.vblank_i;
  assign line_start  = ce_int & hs_act & ~hs_prev_reg;
  assign frame_start = ce_int & vs_act & ~vs_prev_reg;
  assign col_in      = {vid.b_i, vid.g_i, vid.r_i};

  // A counter value of zero means "not yet armed": it only starts counting at the
  // first sync edge, so totals after reset or clock loss are never partial.
  always_comb begin
    wd_next = wd_reg;
    if (ce_int) begin
      wd_next = '0;
    end else if (wd_reg != WD_MAX) begin
      wd_next = wd_reg + 1'b1;
    end
    lost_next = (wd_next == WD_MAX);

    hs_prev_next  = hs_prev_reg;
    vs_prev_next  = vs_prev_reg;
    hs_next       = hs_reg;
    vs_next       = vs_reg;
    hblank_next   = hblank_reg;
    vblank_next   = vblank_reg;
    h_cnt_next    = h_cnt_reg;
    v_cnt_next    = v_cnt_reg;
    h_total_next  = h_total_reg;
    v_total_next  = v_total_reg;
    ref_h_next    = ref_h_reg;
    ref_v_next    = ref_v_reg;
    have_ref_next = have_ref_reg;
    pal_next      = pal_reg;
    valid_next    = valid_reg;

    // Line total belonging to the frame that ends at this ce.
    h_meas = (line_start && h_cnt_reg != '0) ? h_cnt_reg : h_total_reg;

    if (lost_next) begin
      h_cnt_next    = '0;
      v_cnt_next    = '0;
      valid_next    = 1'b0;
      have_ref_next = 1'b0;
      hblank_next   = 1'b1;
      vblank_next   = 1'b1;
    end else if (ce_int) begin
      hs_prev_next = hs_act;
      vs_prev_next = vs_act;
      hs_next      = vid.hs_i;
      vs_next      = vid.vs_i;
      hblank_next  = vid.hblank_i;
      vblank_next  = vid.vblank_i;

      if (line_start) begin
        if (h_cnt_reg != '0) begin
          h_total_next = h_cnt_reg;
        end
        h_cnt_next = 10'd1;
        if (v_cnt_reg != '0 && v_cnt_reg != CNT_MAX) begin
          v_cnt_next = v_cnt_reg + 10'd1;
        end
      end else if (h_cnt_reg != '0 && h_cnt_reg != CNT_MAX) begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end

      if (frame_start) begin
        if (v_cnt_reg != '0) begin
          v_total_next  = v_cnt_reg;
          pal_next      = (int'(v_cnt_reg) >= PAL_THRESHOLD);
          valid_next    = have_ref_reg && (ref_h_reg == h_meas) && (ref_v_reg == v_cnt_reg);
          ref_h_next    = h_meas;
          ref_v_next    = v_cnt_reg;
          have_ref_next = 1'b1;
        end
        v_cnt_next = 10'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s3_reg       <= 1'b0;
      ce_pix_reg   <= 1'b0;
      wd_reg       <= '0;
      lost_reg     <= 1'b0;
      hs_prev_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      hs_reg       <= 1'b0;
      vs_reg       <= 1'b0;
      hblank_reg   <= 1'b1;
      vblank_reg   <= 1'b1;
      h_cnt_reg    <= '0;
      v_cnt_reg    <= '0;
      h_total_reg  <= '0;
      v_total_reg  <= '0;
      ref_h_reg    <= '0;
      ref_v_reg    <= '0;
      have_ref_reg <= 1'b0;
      pal_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      s1_reg       <= clk7_i;
      s2_reg       <= s1_reg;
      s3_reg       <= s2_reg;
      ce_pix_reg   <= ce_int;
      wd_reg       <= wd_next;
      lost_reg     <= lost_next;
      hs_prev_reg  <= hs_prev_next;
      vs_prev_reg  <= vs_prev_next;
      hs_reg       <= hs_next;
      vs_reg       <= vs_next;
      hblank_reg   <= hblank_next;
      vblank_reg   <= vblank_next;
      h_cnt_reg    <= h_cnt_next;
      v_cnt_reg    <= v_cnt_next;
      h_total_reg  <= h_total_next;
      v_total_reg  <= v_total_next;
      ref_h_reg    <= ref_h_next;
      ref_v_reg    <= ref_v_next;
      have_ref_reg <= have_ref_next;
      pal_reg      <= pal_next;
      valid_reg    <= valid_next;
    end
  end

`ifdef VIDEO_SCANLINE_DIM_EN
  logic parity_reg, parity_next, parity_cap;
  logic dim_cap;

  // Parity seen by the pixel captured on this ce, so the first pixel of a line is dimmed too.
  always_comb begin
    parity_cap = parity_reg;
    if (frame_start) begin
      parity_cap = 1'b0;
    end else if (line_start) begin
      parity_cap = ~parity_reg;
    end
    parity_next = lost_next ? 1'b0 : parity_cap;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end

  assign dim_cap = scanline_en_i & parity_cap;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] exp_c;
      logic [7:0] disp_c;
      logic [7:0] col_reg, col_next;

      assign exp_c = {col_in[gi], col_in[gi], col_in[gi][2:1]};
`ifdef VIDEO_SCANLINE_DIM_EN
      assign disp_c = dim_cap ? (exp_c - {2'b00, exp_c[7:2]}) : exp_c;
`else
      assign disp_c = exp_c;
`endif

      always_comb begin
        col_next = col_reg;
        if (lost_next) begin
          col_next = 8'h00;
        end else if (ce_int) begin
          col_next = blank_in ? 8'h00 : disp_c;
        end
      end

      always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
          col_reg <= 8'h00;
        end else begin
          col_reg <= col_next;
        end
      end
    end
  endgenerate

  assign vid.ce_pix_o   = ce_pix_reg;
  assign vid.r_o        = g_chan[0].col_reg;
  assign vid.g_o        = g_chan[1].col_reg;
  assign vid.b_o        = g_chan[2].col_reg;
  assign vid.hs_o       = hs_reg;
  assign vid.vs_o       = vs_reg;
  assign vid.hblank_o   = hblank_reg;
  assign vid.vblank_o   = vblank_reg;
  assign vid.de_o       = ~(hblank_reg | vblank_reg);
  assign h_total_o      = h_total_reg;
  assign v_total_o      = v_total_reg;
  assign pal_o          = pal_reg;
  assign timing_valid_o = valid_reg;
  assign clk_lost_o     = lost_reg;

endmodule

// File: doc/video_frontend_ce.md
Name: video_frontend_ce

Overview:
- Sits between the ZX Next core's raw video outputs and the video mixer, in the 28 MHz system domain.
- Derives a one-cycle pixel enable from the sampled 7 MHz clock level.
- Expands 3:3:3 RGB to 8:8:8, registers and aligns sync/blank, and generates DE.
- Measures line and frame geometry for PAL/NTSC reporting, and blanks video if the pixel clock stops.

Parameters:
- SYNC_ACTIVE_HIGH, 1, polarity of hs_i/vs_i; 1 = asserted high.
- PAL_THRESHOLD, 300, a v_total at or above this value flags PAL.
- WDOG_CYCLES, 16, clk_sys cycles without a pixel enable before clk_lost_o asserts.

Ports:
- clk_sys  in  1  28 MHz system clock.
- reset_n  in  1  synchronous reset, active-low.
- clk7_i  in  1  7 MHz clock level, asynchronous to sampling.
- r_i, g_i, b_i  in  3 each  core colour.
- hs_i, vs_i  in  1 each  core syncs (polarity per SYNC_ACTIVE_HIGH).
- hblank_i, vblank_i  in  1 each  core blanking, active-high.
- ce_pix_o  out  1  pixel enable to mixer.
- r_o, g_o, b_o  out  8 each  expanded colour.
- hs_o, vs_o, hblank_o, vblank_o  out  1 each  registered timing; same polarity as inputs.
- de_o  out  1  ~(hblank_o|vblank_o).
- h_total_o  out  10  pixels per line.
- v_total_o  out  10  lines per frame.
- pal_o  out  1  PAL detected.
- timing_valid_o  out  1  geometry stable.
- clk_lost_o  out  1  pixel clock absent.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - All outputs 0, except hblank_o=vblank_o=1.
  - Counters cleared; sampler flops cleared.
- Pixel enable:
  - clk7_i passes through two synchroniser flops s1, s2, then a history flop s3.
  - ce_int = s2 & ~s3, giving one pulse per clk7 rising edge (every 4 clk_sys nominally).
  - ce_pix_o is ce_int delayed by one cycle.
- Data path:
  - On a ce_int cycle, inputs are captured; the outputs update on the next edge, in the same cycle that ce_pix_o=1.
  - Outputs hold between enables.
  - Colour expansion: r_o = {r,r,r[2:1]}; g and b alike. 3'b111 gives 8'hFF; 3'b100 gives 8'h92.
  - If hblank_i|vblank_i is set at capture, colour outputs are 0.
- Line measurement (evaluated only on ce_int):
  - A line start is hs assertion: hs asserted now, deasserted at the previous ce.
  - At line start: h_total_o <= h_cnt, then h_cnt <= 1. Otherwise h_cnt increments, saturating at 1023.
  - A 448-pixel line reports 448.
- Frame measurement:
  - v_cnt counts line starts; a frame start is vs assertion detected at a line start or at a ce.
  - At frame start: v_total_o <= v_cnt and v_cnt <= 1. Saturates at 1023.
  - pal_o <= (v_cnt >= PAL_THRESHOLD) at frame start.
- Stability:
  - timing_valid_o=1 after two consecutive frame starts report identical h_total and v_total.
  - Any mismatch clears it at that frame start.
  - The first frame start after reset never sets it.
- Watchdog:
  - wd counts clk_sys cycles since the last ce_int and saturates at WDOG_CYCLES.
  - When wd reaches WDOG_CYCLES: clk_lost_o=1, timing_valid_o=0, colour forced 0, hblank_o=vblank_o=1, de_o=0, ce_pix_o stays 0.
  - The next ce_int clears wd and clk_lost_o and resumes normal capture.
  - h_cnt and v_cnt are zeroed on loss, so the first post-recovery line is not reported.
- Simultaneous events: a line start and a frame start on the same ce are both processed; v_cnt restarts at 1.
- Reset mid-line: measurement restarts cleanly; no partial totals are published.

Optional Feature:
- Macro: VIDEO_SCANLINE_DIM_EN.
- When defined:
  - Adds input scanline_en_i (1 bit).
  - An internal line-parity bit toggles at each line start and clears at frame start.
  - When scanline_en_i=1 and parity is odd, each colour output = expanded − (expanded>>2), i.e. 75%. 8'hFF gives 8'hC0.
  - Same latency as the undimmed path.
- When undefined: the port is absent, colour is undimmed, and there is no parity logic.

Test Plan:
- Steady clk7 (2 high/2 low clk_sys), r_i=3'b111, g_i=3'b100, b_i=0, blanks low → ce_pix_o every 4th cycle, 1 cycle after the clk7 rise reaches s2; r_o=FF, g_o=92, b_o=00; de_o=1.
- Blank asserted with colour 3'b111 → r/g/b_o=0, de_o=0, hblank_o=1 on the same ce_pix_o as the capture.
- Synthetic 448-pixel × 312-line raster, three frames → h_total_o=448, v_total_o=312, pal_o=1; timing_valid_o=1 at the 3rd frame start. Switch to 262 lines → pal_o=0, timing_valid_o drops for one frame, then re-asserts.
- Hold clk7_i low for 20 cycles mid-line → clk_lost_o=1 exactly WDOG_CYCLES cycles after the last ce_int; de_o=0, timing_valid_o=0. Restart clk7 → clk_lost_o clears on the first new ce_int.
- reset_n low for 1 cycle mid-frame → all outputs take their reset values; the next reported totals match a full raster with no partial values.
- With VIDEO_SCANLINE_DIM_EN and scanline_en_i=1, white field → even lines r_o=FF, odd lines r_o=C0. With scanline_en_i=0 → all lines FF.
